// File: rtl/wb_user_mem_if.sv
// Bus bundle between the user-area address decoder and wb_user_mem.
// wb_valid is the already-decoded request (cyc & stb & window hit).
interface wb_user_mem_if;
    logic        wb_valid;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wb_valid,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_dat_i,
        output wbs_adr_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wb_valid,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_dat_i,
        input  wbs_adr_i,
        output wbs_ack_o,
        output wbs_dat_o
    );
endinterface

// File: rtl/wb_user_mem.sv
// wb_user_mem: word-addressed 32-bit user memory behind the 0x38xx_xxxx
// window. Every access is acknowledged after DELAYS cycles so firmware sees
// external-memory-like timing. Writes honour byte lanes.
// Optional feature: define WB_USER_MEM_PREFETCH_EN to add a one-entry
// sequential-read prefetch buffer (hit = ack in the cycle after the request).
module wb_user_mem #(
    parameter int DELAYS     = 10,
    parameter int ADDR_WIDTH = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_user_mem_if.slave      bus
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [7:0] CNT_LAST = 8'(DELAYS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [7:0]      cnt_reg;
    logic            ack_reg;
    logic [31:0]     dat_reg;

    logic [ADDR_WIDTH-1:0] word;
    logic [31:0]           rd_word;
    logic [31:0]           wr_mask;
    logic                  access_done;
    logic                  wr_en;
    logic                  pf_hit;
    logic [31:0]           hit_data;
    logic                  unused_adr_bits;

    // Only the word index selects storage; the rest of the address is
    // already qualified by the decoder.
    assign word            = bus.wbs_adr_i[ADDR_WIDTH+1:2];
    assign unused_adr_bits = ^{bus.wbs_adr_i[31:ADDR_WIDTH+2], bus.wbs_adr_i[1:0]};

    // The memory is touched on the edge that enters ACK through the normal
    // latency path. Gating with reset keeps a reset from landing a write.
    assign access_done = wb_rst_i && bus.wb_valid &&
                         (((state_reg == IDLE) && (DELAYS == 1)) ||
                          ((state_reg == BUSY) && (cnt_reg == CNT_LAST)));
    assign wr_en       = access_done && bus.wbs_we_i;

`ifdef WB_USER_MEM_PREFETCH_EN
    localparam logic [ADDR_WIDTH-1:0] WORD_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic                  pf_valid_reg;
    logic [ADDR_WIDTH-1:0] pf_tag_reg;
    logic [31:0]           pf_data_reg;
    logic [ADDR_WIDTH-1:0] acc_word_reg;
    logic                  acc_read_reg;
    logic [ADDR_WIDTH-1:0] fill_word;
    logic [31:0]           fill_data;

    // Natural ADDR_WIDTH wrap makes the last word prefetch word 0.
    assign fill_word = acc_word_reg + WORD_ONE;
`endif

    // Storage is split into one array per byte lane so each lane has a
    // plain single-writer array with its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            // Lane write on the ACK-entry edge when this byte is selected.
            always_ff @(posedge wb_clk_i) begin
                if (wr_en && bus.wbs_sel_i[gi]) begin
                    lane_mem[word] <= bus.wbs_dat_i[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[word];
            assign wr_mask[8*gi +: 8] = {8{bus.wbs_sel_i[gi]}};
`ifdef WB_USER_MEM_PREFETCH_EN
            assign fill_data[8*gi +: 8] = lane_mem[fill_word];
`endif
        end
    endgenerate

`ifdef WB_USER_MEM_PREFETCH_EN
    assign pf_hit   = (state_reg == IDLE) && bus.wb_valid && !bus.wbs_we_i &&
                      pf_valid_reg && (pf_tag_reg == word);
    assign hit_data = pf_data_reg;

    // Prefetch buffer: refill with the following word after every read ack,
    // and merge writes to the buffered word so a hit never returns stale data.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            pf_valid_reg <= 1'b0;
            pf_tag_reg   <= '0;
            pf_data_reg  <= '0;
            acc_word_reg <= '0;
            acc_read_reg <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && bus.wb_valid) begin
                acc_word_reg <= word;
                acc_read_reg <= !bus.wbs_we_i;
            end
            if ((state_reg == ACK) && acc_read_reg) begin
                pf_valid_reg <= 1'b1;
                pf_tag_reg   <= fill_word;
                pf_data_reg  <= fill_data;
            end else if (wr_en && pf_valid_reg && (pf_tag_reg == word)) begin
                pf_data_reg  <= (pf_data_reg & ~wr_mask) | (bus.wbs_dat_i & wr_mask);
            end
        end
    end
`else
    assign pf_hit   = 1'b0;
    assign hit_data = '0;
`endif

    // Access sequencer: IDLE -> BUSY (count) -> ACK (one-cycle ack) -> IDLE.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            ack_reg   <= 1'b0;
            dat_reg   <= 32'd0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.wb_valid) begin
                        if (pf_hit) begin
                            state_reg <= ACK;
                            ack_reg   <= 1'b1;
                            dat_reg   <= hit_data;
                        end else if (DELAYS == 1) begin
                            state_reg <= ACK;
                            ack_reg   <= 1'b1;
                            if (!bus.wbs_we_i) begin
                                dat_reg <= rd_word;
                            end
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= 8'd1;
                        end
                    end
                end
                BUSY: begin
                    if (!bus.wb_valid) begin
                        // Master withdrew the request: drop it silently.
                        state_reg <= IDLE;
                        cnt_reg   <= 8'd0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= ACK;
                        ack_reg   <= 1'b1;
                        cnt_reg   <= 8'd0;
                        if (!bus.wbs_we_i) begin
                            dat_reg <= rd_word;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 8'd0;
                end
            endcase
        end
    end

    assign bus.wbs_ack_o = ack_reg;
    assign bus.wbs_dat_o = dat_reg;
endmodule

// File: tb/tb_wb_user_mem.sv
// Randomized scoreboard bench for wb_user_mem: a main instance (DELAYS=10)
// and a DELAYS=1 instance for back-to-back timing.
module tb_wb_user_mem;
    localparam int DLY     = 10;
    localparam int AW      = 6;
    localparam int DEPTH   = 1 << AW;
    localparam int FAST_AW = 4;
`ifdef WB_USER_MEM_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_user_mem_if bus ();
    wb_user_mem_if fbus ();

    wb_user_mem #(.DELAYS(DLY), .ADDR_WIDTH(AW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus)
    );

    wb_user_mem #(.DELAYS(1), .ADDR_WIDTH(FAST_AW)) dut_fast (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (fbus)
    );

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          due;
        int          id;
    } exp_t;

    exp_t q[$];
    exp_t fq[$];
    exp_t mon_e;
    exp_t fmon_e;
    int   total   = 0;
    int   bad     = 0;
    int   next_id = 0;

    // Reference model: plain word array, last value returned by a read, and
    // the prefetch rule "the word after the last read is buffered".
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rd = 32'd0;
    bit          pf_v    = 1'b0;
    int          pf_t    = 0;

    function automatic logic [31:0] mk_adr(input int word, input int aw);
        logic [31:0] m;
        m = 32'((1 << aw) - 1) << 2;
        return ({8'h38, 24'($urandom)} & ~m) | ((32'(word) << 2) & m);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %08h required %08h", name, got, req);
        end
    endtask

    // Main monitor: every ack consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && bus.wbs_ack_o) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL main_unexpected_ack: ack at cycle %0d, required none", cyc);
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.due || bus.wbs_dat_o !== mon_e.data) begin
                    bad++;
                    $display("FAIL main_txn%0d: got cycle %0d data %08h, required cycle %0d data %08h",
                             mon_e.id, cyc, bus.wbs_dat_o, mon_e.due, mon_e.data);
                end else begin
                    $display("txn %0d %s cycle %0d data %08h ok", mon_e.id,
                             mon_e.rd ? "rd" : "wr", cyc, bus.wbs_dat_o);
                end
            end
        end
    end

    // Fast-instance monitor.
    always @(negedge clk) begin
        if (rst_n && fbus.wbs_ack_o) begin
            total++;
            if (fq.size() == 0) begin
                bad++;
                $display("FAIL fast_unexpected_ack: ack at cycle %0d, required none", cyc);
            end else begin
                fmon_e = fq.pop_front();
                if (cyc != fmon_e.due || fbus.wbs_dat_o !== fmon_e.data) begin
                    bad++;
                    $display("FAIL fast_txn%0d: got cycle %0d data %08h, required cycle %0d data %08h",
                             fmon_e.id, cyc, fbus.wbs_dat_o, fmon_e.due, fmon_e.data);
                end else begin
                    $display("fast txn %0d %s cycle %0d data %08h ok", fmon_e.id,
                             fmon_e.rd ? "rd" : "wr", cyc, fbus.wbs_dat_o);
                end
            end
        end
    end

    // One access on the main instance; called just after a rising edge.
    task automatic main_access(input bit we, input int word, input logic [3:0] sel,
                               input logic [31:0] data, input bit drop);
        exp_t e;
        int   lat;
        bit   got;
        lat   = (PF_EN && !we && pf_v && pf_t == word) ? 1 : DLY;
        e.rd  = !we;
        e.due = cyc + lat;
        e.id  = next_id++;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model_mem[word][8*b +: 8] = data[8*b +: 8];
            e.data = last_rd;
        end else begin
            e.data  = model_mem[word];
            last_rd = e.data;
            pf_v    = 1'b1;
            pf_t    = (word + 1) % DEPTH;
        end
        q.push_back(e);
        bus.wb_valid  = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = mk_adr(word, AW);
        bus.wbs_sel_i = sel;
        bus.wbs_dat_i = data;
        got = 1'b0;
        for (int k = 0; k < lat + 4 && !got; k++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL main_timeout: txn %0d got no ack, required ack at cycle %0d", e.id, e.due);
            if (q.size() > 0) void'(q.pop_back());
        end
        @(posedge clk); #1;
        if (drop) begin
            bus.wb_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // One write on the fast instance (DELAYS = 1).
    task automatic fast_write(input int word, input logic [31:0] data);
        exp_t e;
        bit   got;
        e.rd = 1'b0; e.data = 32'd0; e.due = cyc + 1; e.id = next_id++;
        fq.push_back(e);
        fbus.wb_valid  = 1'b1;
        fbus.wbs_we_i  = 1'b1;
        fbus.wbs_adr_i = mk_adr(word, FAST_AW);
        fbus.wbs_sel_i = 4'hF;
        fbus.wbs_dat_i = data;
        got = 1'b0;
        for (int k = 0; k < 5 && !got; k++) begin
            @(negedge clk);
            if (fbus.wbs_ack_o) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL fast_timeout: write txn %0d got no ack, required ack", e.id);
            if (fq.size() > 0) void'(fq.pop_back());
        end
        @(posedge clk); #1;
        fbus.wb_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lastw;
        int          r;
        int          w;
        bit          seen;
        logic [31:0] fa;
        logic [31:0] fb;
        exp_t        e;

        bus.wb_valid = 1'b0; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'h0;
        bus.wbs_dat_i = 32'd0; bus.wbs_adr_i = 32'd0;
        fbus.wb_valid = 1'b0; fbus.wbs_we_i = 1'b0; fbus.wbs_sel_i = 4'h0;
        fbus.wbs_dat_i = 32'd0; fbus.wbs_adr_i = 32'd0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        chk("reset_dat", bus.wbs_dat_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_no_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        end
        @(posedge clk); #1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) main_access(1'b1, i, 4'hF, $urandom, 1'b1);

        // Latency and byte lanes.
        main_access(1'b1, 4, 4'hF, 32'hDEADBEEF, 1'b1);
        main_access(1'b0, 4, 4'hF, 32'd0, 1'b1);
        main_access(1'b1, 8, 4'hF, 32'hAABBCCDD, 1'b1);
        main_access(1'b1, 8, 4'h5, 32'h11223344, 1'b1);
        main_access(1'b0, 8, 4'hF, 32'd0, 1'b1);
        chk("byte_lane_model", model_mem[8], 32'hAA22CC44);

        // Sequential reads, write into the buffered word, last-word wrap.
        main_access(1'b0, 5, 4'hF, 32'd0, 1'b1);
        main_access(1'b0, 6, 4'hF, 32'd0, 1'b1);
        main_access(1'b1, 7, 4'h1, 32'h000000FF, 1'b1);
        main_access(1'b0, 7, 4'hF, 32'd0, 1'b1);
        main_access(1'b0, DEPTH - 1, 4'hF, 32'd0, 1'b1);
        main_access(1'b0, 0, 4'hF, 32'd0, 1'b1);

        // Abort: drop valid in cycle 4 of a write.
        bus.wb_valid  = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = mk_adr(9, AW);
        bus.wbs_sel_i = 4'hF;
        bus.wbs_dat_i = 32'h12345678;
        repeat (4) @(posedge clk);
        #1 bus.wb_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < DLY + 4; k++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) seen = 1'b1;
        end
        chk("abort_no_ack", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
        main_access(1'b0, 9, 4'hF, 32'd0, 1'b1);

        // Reset in the middle of a write.
        bus.wb_valid  = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = mk_adr(10, AW);
        bus.wbs_sel_i = 4'hF;
        bus.wbs_dat_i = ~model_mem[10];
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        chk("midreset_dat", bus.wbs_dat_o, 32'd0);
        bus.wb_valid = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        pf_v    = 1'b0;
        last_rd = 32'd0;
        @(posedge clk); #1;
        main_access(1'b0, 10, 4'hF, 32'd0, 1'b1);

        // Randomized mix: writes, sequential reads, random reads, some
        // back-to-back requests.
        lastw = 10;
        repeat (120) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                w = $urandom_range(0, DEPTH - 1);
                main_access(1'b1, w, 4'($urandom), $urandom, $urandom_range(0, 3) != 0);
            end else begin
                w = (r < 7) ? (lastw + 1) % DEPTH : $urandom_range(0, DEPTH - 1);
                lastw = w;
                main_access(1'b0, w, 4'hF, 32'd0, $urandom_range(0, 3) != 0);
            end
        end
        bus.wb_valid = 1'b0;
        @(posedge clk); #1;

        // Back-to-back reads on the DELAYS = 1 instance.
        fa = $urandom;
        fb = $urandom;
        fast_write(2, fa);
        fast_write(3, fb);
        e.rd = 1'b1; e.data = fa; e.due = cyc + 1; e.id = next_id++;
        fq.push_back(e);
        e.rd = 1'b1; e.data = fb; e.due = cyc + 3; e.id = next_id++;
        fq.push_back(e);
        fbus.wb_valid  = 1'b1;
        fbus.wbs_we_i  = 1'b0;
        fbus.wbs_adr_i = mk_adr(2, FAST_AW);
        @(posedge clk); #1;
        @(posedge clk); #1;
        fbus.wbs_adr_i = mk_adr(3, FAST_AW);
        @(posedge clk); #1;
        @(posedge clk); #1;
        fbus.wb_valid = 1'b0;

        // Drain and confirm nothing is left outstanding.
        for (int k = 0; k < 20 && (q.size() != 0 || fq.size() != 0); k++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("main_queue_empty", 32'(q.size()), 32'd0);
        chk("fast_queue_empty", 32'(fq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_user_mem.md
# wb_user_mem

User-memory Wishbone slave that sits directly downstream of the user-area address decoder and serves the 0x38xx_xxxx window. It holds a word-addressed 32-bit memory with byte-lane writes. Every access is acknowledged after a programmable fixed latency, so firmware sees realistic external-memory timing. An optional sequential-read prefetch buffer shortens the latency of in-order reads.

## Interface
Parameters:
- DELAYS, 10: access latency in cycles, from the first cycle of `wb_valid` to `wbs_ack_o`; legal range 1..255.
- ADDR_WIDTH, 10: word-address width; memory depth is 2^ADDR_WIDTH words.

Ports:
- wb_clk_i  in  1  single clock; all state updates on the rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- wb_valid  in  1  request select from the decoder (cyc & stb & window hit).
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte enables; bit i selects data[8i+7:8i].
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address; only bits [ADDR_WIDTH+1:2] are used, all other bits are ignored.
- wbs_ack_o  out  1  single-cycle acknowledge; registered.
- wbs_dat_o  out  32  read data; registered; valid in the ack cycle.

## Operation
- The FSM has three states: IDLE, BUSY, ACK. Reset state is IDLE, with cnt = 0, wbs_ack_o = 0 and wbs_dat_o = 0. Memory contents are not reset.
- Transitions out of IDLE (wb_valid = 1):
  - DELAYS = 1: go to ACK.
  - Otherwise: go to BUSY with cnt = 1.
- Transitions out of BUSY:
  - wb_valid = 0: abort. Return to IDLE, no memory write, no ack.
  - cnt == DELAYS-1: go to ACK.
  - Otherwise: cnt = cnt + 1.
- Actions on entry to ACK, in the same edge:
  - Write: memory[word] is updated only on lanes where wbs_sel_i = 1.
  - Read: the full word is registered into wbs_dat_o.
- wbs_ack_o is high only in the ACK state, for exactly one cycle. ACK always goes to IDLE on the next edge.
- wbs_dat_o holds its last value outside the ack cycle. Writes do not change wbs_dat_o.
- Back-to-back requests: wb_valid still high in the cycle after ACK starts a new access from IDLE.
- cnt is 8 bits wide. It is never compared above DELAYS-1, so it cannot wrap.

## Timing
- Let cycle 0 be the first cycle in which wb_valid = 1 is seen in IDLE. wbs_ack_o is high in cycle DELAYS.
- Write data and sel are sampled on the edge that enters ACK, i.e. the end of cycle DELAYS-1. The master holds them stable for the whole access.
- Minimum request-to-request spacing is DELAYS+1 cycles.
- Reset asserted mid-access:
  - FSM, cnt, ack and wbs_dat_o clear immediately.
  - No write occurs.
  - After release the block is in IDLE.

## Configuration
- Macro WB_USER_MEM_PREFETCH_EN.
- With the macro defined:
  - Adds a prefetch buffer made of pf_valid, pf_tag[ADDR_WIDTH-1:0] and pf_data[31:0]. All three reset to 0.
  - Fill: on every read ACK of word w, the edge leaving ACK loads pf_data = memory[w+1], pf_tag = w+1 (mod 2^ADDR_WIDTH, so the last word wraps to 0) and pf_valid = 1.
  - Hit: a read request in IDLE whose word equals pf_tag while pf_valid = 1 goes straight to ACK and returns pf_data. Ack is in cycle 1, regardless of DELAYS. A hit also triggers the next fill.
  - Write update: a write ACK to pf_tag merges the selected bytes into pf_data, so the buffer never returns stale data.
  - Miss: behaviour is the normal DELAYS path.
- Without the macro: no buffer exists, and every access takes DELAYS cycles.

## Test plan
- Reset value: drive wb_rst_i = 0 and hold 3 cycles -> wbs_ack_o = 0 and wbs_dat_o = 0. Release -> no ack while wb_valid = 0.
- Latency: with DELAYS = 10, write 0xDEADBEEF with sel = 0xF to 0x38000010 -> ack in cycle 10 only. Then read 0x38000010 -> ack in cycle 10 and wbs_dat_o = 0xDEADBEEF.
- Byte lanes: write 0x11223344 with sel = 0x5 over a word containing 0xAABBCCDD -> read returns 0xAA22CC44.
- Abort: drop wb_valid in cycle 4 of a write of 0x12345678 -> no ack and memory unchanged. The next access runs with full latency.
- Back-to-back with DELAYS = 1: two consecutive reads with wb_valid held high -> acks in cycles 1 and 3, each returning its own word.
- Prefetch (macro defined, DELAYS = 10):
  - Read word 5 -> ack in cycle 10. Read word 6 -> ack in cycle 1 with the correct data.
  - Write 0x000000FF with sel = 0x1 to word 7, then read word 7 -> updated data.
  - Read of the last word followed by a read of word 0 hits.
